// File: rtl/bus_sim_pkg.sv
// Shared types and constants for the simulation RAM slave: FSM states,
// default reset-vector base, LFSR seed/taps and the byte-lane merge helper.
package bus_sim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        ACCEPT = 2'd2
    } bus_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

    // x^16 + x^14 + x^13 + x^11 + 1 expressed as feedback taps on bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] data,
        input logic [3:0]  be
    );
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = data[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_wait_lfsr.sv
// 16-bit maximal-length Fibonacci LFSR that steps once per advance strobe;
// used to randomise stall lengths when BUS_SIM_RAM_RANDOM_WAIT_EN is defined.
module bus_wait_lfsr
    import bus_sim_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = ^(lfsr_q & LFSR_TAPS);
        lfsr_d   = lfsr_q;
        if (advance) begin
            lfsr_d = {lfsr_q[14:0], feedback};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/bus_sim_ram.sv
// Word-addressed Avalon-style RAM slave with byte enables, programmable
// waitrequest stalls, sticky range checking and a side preload port.
// Optional: define BUS_SIM_RAM_RANDOM_WAIT_EN for LFSR-randomised stall lengths.
module bus_sim_ram
    import bus_sim_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 0,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [31:0]   address,
    input  logic          read,
    input  logic          write,
    output logic          waitrequest,
    input  logic [31:0]   writedata,
    input  logic [3:0]    byteenable,
    output logic [31:0]   readdata,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic          range_err
);

    logic [31:0] mem [DEPTH_WORDS];

    bus_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] readdata_q, readdata_d;
    logic        range_err_q, range_err_d;

    logic [31:0]   word_off;
    logic          hit;
    logic [AW-1:0] idx;
    logic          req;
    logic          accept;
    logic          do_write;
    logic          do_read;
    logic          mem_wr_en;
    logic [31:0]   mem_wdata;
    logic [7:0]    stall_len;

`ifdef BUS_SIM_RAM_RANDOM_WAIT_EN
    logic [15:0] lfsr_value;

    bus_wait_lfsr u_wait_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (accept),
        .value   (lfsr_value)
    );

    assign stall_len = 8'(lfsr_value % 16'(WAIT_CYCLES + 1));
`else
    assign stall_len = 8'(WAIT_CYCLES);
`endif

    always_comb begin
        word_off = (address - BASE_ADDR) >> 2;
        hit      = (address >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
        idx      = word_off[AW-1:0];
        req      = read | write;
    end

    // Waitrequest is combinational so a zero-length stall completes in the request cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        waitrequest = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (stall_len == 8'd0) begin
                        accept = 1'b1;
                    end else begin
                        waitrequest = 1'b1;
                        cnt_d       = stall_len - 8'd1;
                        state_d     = (stall_len == 8'd1) ? ACCEPT : STALL;
                    end
                end
            end
            STALL: begin
                waitrequest = 1'b1;
                cnt_d       = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                accept  = req;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read+write together is handled as a write but still flagged as a protocol error.
    always_comb begin
        do_write    = accept & write;
        do_read     = accept & read & ~write;
        mem_wr_en   = do_write & hit;
        mem_wdata   = merge_bytes(mem[idx], writedata, byteenable);
        readdata_d  = readdata_q;
        range_err_d = range_err_q;
        if (do_write && (!hit || read)) begin
            range_err_d = 1'b1;
        end
        if (do_read) begin
            if (hit) begin
                readdata_d = mem[idx];
            end else begin
                readdata_d = 32'd0;
                if (address != 32'd0) begin
                    range_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            readdata_q  <= 32'd0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            readdata_q  <= readdata_d;
            range_err_q <= range_err_d;
        end
    end

    // Load port is written last so it overrides a bus write to the same word.
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            mem[idx] <= mem_wdata;
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign readdata  = readdata_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_bus_sim_ram.sv
// Self-checking bench for bus_sim_ram: one instance with no stalls and one
// with three stall cycles, checked through a readdata scoreboard.
module tb_bus_sim_ram;

   localparam logic [31:0] BASE = 32'hBFC00000;

   logic clk;
   logic resetN;

   logic [31:0] address   [2];
   logic        busRead   [2];
   logic        busWrite  [2];
   logic [31:0] writedata [2];
   logic [3:0]  byteEn    [2];
   logic        loadEn    [2];
   logic [5:0]  loadAddr  [2];
   logic [31:0] loadData  [2];

   logic        wait0, wait1;
   logic [31:0] readdata0, readdata1;
   logic        rangeErr0, rangeErr1;

   int checks = 0;
   int errors = 0;
   logic [31:0] expQ [$];

   bus_sim_ram #(.DEPTH_WORDS(64), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset_n(resetN), .address(address[0]), .read(busRead[0]),
      .write(busWrite[0]), .waitrequest(wait0), .writedata(writedata[0]),
      .byteenable(byteEn[0]), .readdata(readdata0), .load_en(loadEn[0]),
      .load_addr(loadAddr[0]), .load_data(loadData[0]), .range_err(rangeErr0)
   );

   bus_sim_ram #(.DEPTH_WORDS(64), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .reset_n(resetN), .address(address[1]), .read(busRead[1]),
      .write(busWrite[1]), .waitrequest(wait1), .writedata(writedata[1]),
      .byteenable(byteEn[1]), .readdata(readdata1), .load_en(loadEn[1]),
      .load_addr(loadAddr[1]), .load_data(loadData[1]), .range_err(rangeErr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rdOf(input int s);
      return (s == 0) ? readdata0 : readdata1;
   endfunction

   function automatic logic waitOf(input int s);
      return (s == 0) ? wait0 : wait1;
   endfunction

   function automatic logic errOf(input int s);
      return (s == 0) ? rangeErr0 : rangeErr1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic loadWord(input int s, input logic [5:0] idx, input logic [31:0] data);
      @(negedge clk);
      loadEn[s] = 1'b1;
      loadAddr[s] = idx;
      loadData[s] = data;
      @(negedge clk);
      loadEn[s] = 1'b0;
   endtask

   // Drives one bus transaction, counts waitrequest-high cycles and, for a
   // plain read, compares readdata against the scoreboard after acceptance.
   task automatic applyStimulus(input int s, input string tag, input logic [31:0] addr,
                                input logic rd, input logic wr, input logic [31:0] wd,
                                input logic [3:0] be, input int expWaits, input logic [31:0] expData);
      int waits;
      logic accepted;
      logic [31:0] expected;
      @(negedge clk);
      address[s] = addr;
      busRead[s] = rd;
      busWrite[s] = wr;
      writedata[s] = wd;
      byteEn[s] = be;
      if (rd && !wr) expQ.push_back(expData);
      waits = 0;
      accepted = 1'b0;
      for (int c = 0; c < 20 && !accepted; c++) begin
         #1;
         if (waitOf(s)) begin
            waits++;
            @(negedge clk);
         end else begin
            accepted = 1'b1;
         end
      end
      checkOutput({tag, "_accept"}, 32'(accepted), 32'd1);
      checkOutput({tag, "_waits"}, 32'(waits), 32'(expWaits));
      @(posedge clk);
      #1;
      busRead[s] = 1'b0;
      busWrite[s] = 1'b0;
      if (rd && !wr && expQ.size() > 0) begin
         expected = expQ.pop_front();
         checkOutput({tag, "_rdata"}, rdOf(s), expected);
      end
   endtask

   initial begin
      resetN = 1'b0;
      for (int s = 0; s < 2; s++) begin
         address[s] = 32'd0; busRead[s] = 1'b0; busWrite[s] = 1'b0;
         writedata[s] = 32'd0; byteEn[s] = 4'h0;
         loadEn[s] = 1'b0; loadAddr[s] = 6'd0; loadData[s] = 32'd0;
      end
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      #1;
      for (int s = 0; s < 2; s++) begin
         checkOutput("reset_rdata", rdOf(s), 32'd0);
         checkOutput("reset_err", 32'(errOf(s)), 32'd0);
         checkOutput("reset_wait", 32'(waitOf(s)), 32'd0);
      end

      $display("[TB] zero-wait instance");
      loadWord(0, 6'd1, 32'h8D09002C);
      applyStimulus(0, "rd_w1", BASE + 32'h4, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'h8D09002C);
      checkOutput("rd_w1_err", 32'(rangeErr0), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("rd_hold", readdata0, 32'h8D09002C);

      loadWord(0, 6'd12, 32'h11223344);
      applyStimulus(0, "wr_lane1", BASE + 32'h30, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0010, 0, 32'd0);
      checkOutput("wr_keeps_rdata", readdata0, 32'h8D09002C);
      applyStimulus(0, "rd_lane1", BASE + 32'h30, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'h1122CC44);
      applyStimulus(0, "wr_be0", BASE + 32'h30, 1'b0, 1'b1, 32'h00000000, 4'b0000, 0, 32'd0);
      applyStimulus(0, "rd_be0", BASE + 32'h30, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'h1122CC44);
      applyStimulus(0, "wr_top", BASE + 32'hFC, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, 0, 32'd0);
      applyStimulus(0, "rd_top", BASE + 32'hFC, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'hCAFEF00D);

      // Load and bus write in the same cycle, first to one word, then to two.
      @(negedge clk);
      loadEn[0] = 1'b1; loadAddr[0] = 6'd5; loadData[0] = 32'h0;
      address[0] = BASE + 32'h14; busWrite[0] = 1'b1; writedata[0] = 32'hFFFFFFFF; byteEn[0] = 4'hF;
      @(negedge clk);
      loadEn[0] = 1'b0; busWrite[0] = 1'b0;
      applyStimulus(0, "rd_same_word", BASE + 32'h14, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'h0);
      @(negedge clk);
      loadEn[0] = 1'b1; loadAddr[0] = 6'd6; loadData[0] = 32'h12345678;
      address[0] = BASE + 32'h1C; busWrite[0] = 1'b1; writedata[0] = 32'h87654321; byteEn[0] = 4'hF;
      @(negedge clk);
      loadEn[0] = 1'b0; busWrite[0] = 1'b0;
      applyStimulus(0, "rd_load_w6", BASE + 32'h18, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'h12345678);
      applyStimulus(0, "rd_bus_w7", BASE + 32'h1C, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'h87654321);

      $display("[TB] three-wait instance");
      loadWord(1, 6'd2, 32'h01020304);
      applyStimulus(1, "s_rd_w2", BASE + 32'h8, 1'b1, 1'b0, 32'd0, 4'h0, 3, 32'h01020304);
      loadWord(1, 6'd3, 32'hFFFFFFFF);
      applyStimulus(1, "s_wr_w3", BASE + 32'hC, 1'b0, 1'b1, 32'h11223344, 4'b1001, 3, 32'd0);
      applyStimulus(1, "s_rd_w3", BASE + 32'hC, 1'b1, 1'b0, 32'd0, 4'h0, 3, 32'h11FFFF44);

      // Write request withdrawn mid-stall must not reach memory.
      @(negedge clk);
      address[1] = BASE + 32'h8; busWrite[1] = 1'b1; writedata[1] = 32'h0; byteEn[1] = 4'hF;
      @(negedge clk);
      #1;
      checkOutput("drop_stall_wait", 32'(wait1), 32'd1);
      busWrite[1] = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("drop_idle_wait", 32'(wait1), 32'd0);
      applyStimulus(1, "s_rd_dropped", BASE + 32'h8, 1'b1, 1'b0, 32'd0, 4'h0, 3, 32'h01020304);

      // Reset asserted while a write is stalled discards it.
      loadWord(1, 6'd4, 32'h55555555);
      @(negedge clk);
      address[1] = BASE + 32'h10; busWrite[1] = 1'b1; writedata[1] = 32'h0; byteEn[1] = 4'hF;
      @(negedge clk);
      #1;
      checkOutput("rst_stall_wait", 32'(wait1), 32'd1);
      resetN = 1'b0;
      busWrite[1] = 1'b0;
      #1;
      checkOutput("rst_wait", 32'(wait1), 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      applyStimulus(1, "s_rd_after_rst", BASE + 32'h10, 1'b1, 1'b0, 32'd0, 4'h0, 3, 32'h55555555);
      checkOutput("s_err_clean", 32'(rangeErr1), 32'd0);

      applyStimulus(1, "s_rd_wr_both", BASE + 32'h8, 1'b1, 1'b1, 32'hAAAAAAAA, 4'hF, 3, 32'd0);
      checkOutput("s_both_err", 32'(rangeErr1), 32'd1);
      applyStimulus(1, "s_rd_both_word", BASE + 32'h8, 1'b1, 1'b0, 32'd0, 4'h0, 3, 32'hAAAAAAAA);

      $display("[TB] range checks");
      applyStimulus(0, "rd_prime", BASE + 32'hFC, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'hCAFEF00D);
      applyStimulus(0, "rd_addr0", 32'd0, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'd0);
      checkOutput("addr0_err", 32'(rangeErr0), 32'd0);
      applyStimulus(0, "rd_prime2", BASE + 32'h4, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'h8D09002C);
      applyStimulus(0, "rd_miss", BASE + 32'h100, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'd0);
      checkOutput("miss_err", 32'(rangeErr0), 32'd1);
      applyStimulus(0, "rd_after_miss", BASE + 32'h4, 1'b1, 1'b0, 32'd0, 4'h0, 0, 32'h8D09002C);
      checkOutput("miss_err_sticky", 32'(rangeErr0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/bus_sim_ram.md
Name: bus_sim_ram

Overview:
Parametrised word-addressed RAM slave for the CPU's Avalon-style memory bus (address/read/write/waitrequest/byteenable). It replaces per-test hand-written memory arrays, with:
- configurable depth and base address;
- correct per-lane byte enables;
- programmable waitrequest stalls;
- range checking;
- a side load port for preloading programs.

It sits between mips_cpu_bus and the testbench stimulus, and is synthesizable.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; index width AW = $clog2(DEPTH_WORDS)
BASE_ADDR, 32'hBFC00000, byte address of word 0 (CPU reset vector)
WAIT_CYCLES, 0, waitrequest-high cycles inserted before each access is accepted (0..255)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
address  in  32  byte address from CPU; bits [1:0] ignored
read  in  1  read request
write  in  1  write request
waitrequest  out  1  slave stall; master holds address/read/write/writedata/byteenable stable while high
writedata  in  32  write data
byteenable  in  4  lane enables; bit i selects writedata[8i+7:8i]
readdata  out  32  registered read data
load_en  in  1  side-port preload strobe
load_addr  in  AW  side-port word index
load_data  in  32  side-port full-word data
range_err  out  1  sticky: out-of-range or read+write protocol violation seen

Behaviour:
- Reset (async assert, sync release): state IDLE, readdata=0, range_err=0, stall counter=0. Memory contents are not cleared.
- Decode: hit = (address >= BASE_ADDR) && ((address-BASE_ADDR)>>2 < DEPTH_WORDS); idx = (address-BASE_ADDR)>>2 truncated to AW.
- FSM states: IDLE, STALL, ACCEPT.
- IDLE, no request: waitrequest=0.
- IDLE, read|write with WAIT_CYCLES=0: waitrequest=0 (combinational); access performed at this edge; stay IDLE.
- IDLE, read|write with WAIT_CYCLES>0: waitrequest=1; counter<=WAIT_CYCLES-1; go to STALL (or ACCEPT if WAIT_CYCLES=1).
- STALL: waitrequest=1; decrement; at 0 go to ACCEPT.
- ACCEPT: waitrequest=0; access performed at this edge; go to IDLE.
- Net cost: each request sees exactly WAIT_CYCLES cycles with waitrequest high.
- Read data: readdata<=mem[idx] at the accepting edge, i.e. valid from the next cycle. Readdata holds until the next accepted read.
- Address 0: a read returns 0 without flagging an error (CPU halt fetch).
- Read of any other miss: readdata<=0 and range_err<=1.
- Write: for each i with byteenable[i]=1, mem[idx][8i+7:8i]<=writedata[8i+7:8i]. byteenable=0000 writes nothing.
- Write miss: ignored; range_err<=1.
- read and write both high: treated as write; range_err<=1.
- load_en: mem[load_addr]<=load_data every cycle, independent of the FSM.
  - Load and bus write to the same word in the same cycle: the load wins entirely.
  - Different words: both are performed.
- Request dropped (read/write low) during STALL: FSM continues to ACCEPT, then performs no access.
- reset_n low mid-STALL: return to IDLE; the pending access is discarded.

Optional Feature:
Macro BUS_SIM_RAM_RANDOM_WAIT_EN.
- Defined: the stall length per request is taken from a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) modulo (WAIT_CYCLES+1), giving 0..WAIT_CYCLES. The LFSR advances once per accepted access.
- Undefined: the stall length is fixed at WAIT_CYCLES and no LFSR logic exists.

Decomposition:
- Package bus_sim_pkg holds:
  - the state enum typedef (IDLE/STALL/ACCEPT);
  - the default BASE_ADDR constant;
  - the LFSR seed/taps constants;
  - a function for byte-lane merge (old word, data, byteenable -> new word).
- One sub-module, bus_wait_lfsr (16-bit LFSR with advance strobe), instantiated only under the macro.

Test Plan:
- WAIT_CYCLES=0, preload word 1 = 32'h8D09002C via load port; read 0xBFC00004 -> waitrequest stays 0; readdata=32'h8D09002C the next cycle; range_err=0.
- Write 32'hAABBCCDD with byteenable 4'b0010 to 0xBFC00030 over preloaded 32'h11223344 -> readback 32'h1122CC44.
- WAIT_CYCLES=3, read -> waitrequest high exactly 3 cycles; data valid the cycle after the accepting edge.
- Read 0xBFC00000+4*DEPTH_WORDS -> readdata=0, range_err=1 (sticky); read of address 0 alone -> readdata=0, range_err=0.
- reset_n pulsed low during STALL of a write -> target word unchanged; waitrequest=0; state IDLE.
- Same cycle: load_en to idx 5 with 32'h0 and bus write 32'hFFFFFFFF to idx 5 -> mem[5]=32'h0.
